prog_loader: RTL
================

Name: prog_loader

Overview:
Boot-time writer for the processor's instruction memory: the write side of the port the processor core only reads through during fetch. Accepts a framed byte stream over a valid/ready handshake and packs bytes into instruction words. Writes the words sequentially from address 0 and holds the processor core in reset until a load completes with a correct checksum. Sits beside the processor core at top level, driving the memory write port and the core's reset input.

Parameters:
INSN_W, 16, instruction word width in bits; must be a multiple of 8, range 8..32.
ADDR_W, 8, instruction memory address width; capacity is 2^ADDR_W words.

Ports:
clk  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-low reset.
start_i  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
rx_data  in  8  stream byte.
rx_valid  in  1  rx_data is valid.
rx_ready  out  1  loader accepts a byte; a transfer occurs when rx_valid and rx_ready are both high on a clock edge.
mem_we  out  1  instruction memory write strobe, one cycle per word.
mem_addr  out  ADDR_W  write address.
mem_wdata  out  INSN_W  write data.
cpu_reset  out  1  active-high reset to the processor core.
busy  out  1  load in progress.
done  out  1  last load succeeded; sticky until the next start_i.
error  out  1  last load failed; sticky until the next start_i.

Behaviour:
- Frame format, bytes in order:
  - LEN_HI, LEN_LO: word count N, big-endian, 16 bits.
  - N×(INSN_W/8) data bytes, MSB first within each word.
  - CKSUM: XOR of every preceding frame byte, including the length bytes.
- Reset (async assert, sync release) values:
  - state=IDLE, cpu_reset=1.
  - rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, done=0, error=0.
- State IDLE:
  - rx_ready=0, cpu_reset=1.
  - On start_i go to LEN_HI; clear the checksum accumulator, the address counter, the byte index, done and error.
- LEN_HI, LEN_LO: rx_ready=1; each accepted byte is latched and XORed into the accumulator.
- After LEN_LO is accepted:
  - N > 2^ADDR_W → ERR.
  - N = 0 → CKSUM.
  - Otherwise → DATA.
- DATA:
  - rx_ready=1; each accepted byte shifts into the word assembler and updates the accumulator.
  - On the last byte of a word → WRITE.
- WRITE (exactly one cycle):
  - rx_ready=0, mem_we=1, mem_addr=current address, mem_wdata=assembled word.
  - Address counter increments at the end of the cycle.
  - If the number of words written equals N → CKSUM; else → DATA.
  - Net throughput: one word per INSN_W/8+1 cycles with rx_valid held high.
- CKSUM: rx_ready=1; the accepted byte is compared with the accumulator.
  - Match → DONE.
  - Mismatch → ERR.
- DONE:
  - done=1, cpu_reset=0 starting the cycle after the checksum byte is accepted.
  - rx_ready=0.
- ERR:
  - error=1, cpu_reset remains 1, rx_ready=0.
  - Words already written are not erased.
- busy=1 in LEN_HI, LEN_LO, DATA, WRITE and CKSUM.
- start_i while busy is ignored.
- start_i in DONE or ERR re-arms the load:
  - cpu_reset returns to 1 in the next cycle.
  - done and error clear in the next cycle.
- rx_valid gaps of any length are allowed in any receiving state; no timeout.
- mem_we is never asserted outside WRITE.
- Reset asserted mid-load: immediate return to reset values; the partial word is discarded.
- Bytes presented while rx_ready=0 are neither consumed nor checksummed.

Decomposition:
- State encodings (IDLE, LEN_HI, LEN_LO, DATA, WRITE, CKSUM, DONE, ERR) go in the shared definitions include as defines.
- The frame-length field width (16) also goes there.
- One sub-module is natural: prog_loader_wpack, the byte-to-word shift assembler.
  - Inputs: clk, Reset, clear, shift, byte.
  - Outputs: word, last_byte flag.
  - Implemented as a byte index counter plus shift register.

Test Plan:
- Good load, defaults, bytes 00 02 12 34 AB CD 42 with rx_valid held high → mem_we twice: addr0=0x1234, addr1=0xABCD; done=1 and cpu_reset=0 one cycle after 0x42 is accepted; error=0.
- Same frame with checksum 0x43 → both writes still occur; error=1, done=0, cpu_reset stays 1; a following start_i plus a correct frame yields done=1.
- Empty frame 00 00 00 → no mem_we, done=1, cpu_reset=0.
- Length overflow 01 01 (257 > 256) → ERR immediately after LEN_LO; rx_ready=0 thereafter; no writes.
- Good-load frame with random rx_valid gaps of 0–5 cycles → identical writes and result; rx_ready=0 during each WRITE cycle; no byte lost or duplicated.
- Reset pulled low after the first data byte of a word → all outputs at reset values asynchronously; after release and a new start_i, a full good load writes address 0 correctly.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: frame field widths,
// FSM state encoding and small state-classification helpers.
package prog_loader_pkg;

  localparam int LEN_W  = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CKSUM  = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

  // States in which a frame byte may be taken from the stream.
  function automatic logic accepts_byte(input state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CKSUM);
  endfunction

  function automatic logic is_busy(input state_e s);
    return accepts_byte(s) || (s == ST_WRITE);
  endfunction

  function automatic logic is_rearmable(input state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/prog_loader_wpack.sv
// Byte-to-word assembler: shifts stream bytes in MSB first and flags the byte
// that completes the current instruction word.
module prog_loader_wpack
  import prog_loader_pkg::*;
#(
  parameter int INSN_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [INSN_W-1:0] word_o,
  output logic              last_byte_o
);

  localparam int BYTES = INSN_W / BYTE_W;

  logic [2:0]        idx_q, idx_d;
  logic [INSN_W-1:0] word_q, word_d;
  logic [INSN_W-1:0] shifted;

  generate
    if (INSN_W == BYTE_W) begin : g_single
      assign shifted = byte_i;
    end else begin : g_multi
      assign shifted = {word_q[INSN_W-BYTE_W-1:0], byte_i};
    end
  endgenerate

  assign last_byte_o = (idx_q == 3'(BYTES - 1));
  assign word_o      = word_q;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d  = '0;
      word_d = '0;
    end else if (shift_i) begin
      word_d = shifted;
      idx_d  = last_byte_o ? 3'd0 : idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot-time instruction memory writer: receives a length/data/checksum frame,
// writes words from address 0 and releases the core only after a clean load.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int INSN_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [INSN_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Largest legal word count is the full memory capacity, so one extra bit.
  localparam logic [LEN_W:0] CAPACITY = (LEN_W+1)'(1) << ADDR_W;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  wcount_q, wcount_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cksum_q, cksum_d;

  logic              accept;
  logic              pack_clear;
  logic              pack_shift;
  logic              last_byte;
  logic [INSN_W-1:0] word;
  logic [LEN_W-1:0]  new_len;
  logic [LEN_W-1:0]  wcount_inc;

  assign accept     = rx_valid && rx_ready;
  assign new_len    = {len_q[LEN_W-1:8], rx_data};
  assign wcount_inc = wcount_q + LEN_W'(1);

  prog_loader_wpack #(
    .INSN_W (INSN_W)
  ) u_wpack (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (pack_clear),
    .shift_i     (pack_shift),
    .byte_i      (rx_data),
    .word_o      (word),
    .last_byte_o (last_byte)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wcount_d   = wcount_q;
    addr_d     = addr_q;
    cksum_d    = cksum_q;
    pack_clear = 1'b0;
    pack_shift = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_d    = ST_LEN_HI;
          len_d      = '0;
          wcount_d   = '0;
          addr_d     = '0;
          cksum_d    = '0;
          pack_clear = 1'b1;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d   = {rx_data, 8'h00};
          cksum_d = cksum_q ^ rx_data;
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d   = new_len;
          cksum_d = cksum_q ^ rx_data;
          if ({1'b0, new_len} > CAPACITY) begin
            state_d = ST_ERR;
          end else if (new_len == '0) begin
            state_d = ST_CKSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          pack_shift = 1'b1;
          cksum_d    = cksum_q ^ rx_data;
          if (last_byte) begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        addr_d   = addr_q + ADDR_W'(1);
        wcount_d = wcount_inc;
        state_d  = (wcount_inc == len_q) ? ST_CKSUM : ST_DATA;
      end
      ST_CKSUM: begin
        if (accept) begin
          state_d = (rx_data == cksum_q) ? ST_DONE : ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      wcount_q <= '0;
      addr_q   <= '0;
      cksum_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wcount_q <= wcount_d;
      addr_q   <= addr_d;
      cksum_q  <= cksum_d;
    end
  end

  // The core stays in reset everywhere except after a verified load.
  assign rx_ready  = accepts_byte(state_q);
  assign mem_we    = (state_q == ST_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = word;
  assign cpu_reset = (state_q != ST_DONE);
  assign busy      = is_busy(state_q);
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERR);

endmodule
